// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
//   Bundles the fetch stage's control inputs, the instruction BRAM bus and the
//   outputs toward the F/D pipeline register.
//
//   slave  modport : used by fetch_stage
//     in : stall, redirect, redirect_pc[31:0], halt, imem_rdata[31:0]
//     out: imem_addr[ADDR_W-1:0], f_pc[31:0], f_inst[31:0], f_valid,
//          fetch_count[31:0]
//   master modport : used by the environment (core control, BRAM, F/D reg)
// -----------------------------------------------------------------------------
interface fetch_stage_if #(
  parameter int ADDR_W = 14
) ();
  logic              stall;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              halt;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic [31:0]       f_pc;
  logic [31:0]       f_inst;
  logic              f_valid;
  logic [31:0]       fetch_count;

  modport slave (
    input  stall, redirect, redirect_pc, halt, imem_rdata,
    output imem_addr, f_pc, f_inst, f_valid, fetch_count
  );

  modport master (
    output stall, redirect, redirect_pc, halt, imem_rdata,
    input  imem_addr, f_pc, f_inst, f_valid, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage. Owns the PC, addresses the synchronous instruction
//   BRAM and presents f_pc / f_inst / f_valid to the F/D register. Supports
//   stall hold, redirect, a one-cycle boot after reset, a sticky halt and a
//   counter of instructions handed to F/D.
//
//   Ports
//     clk   : clock, rising edge
//     rstn  : asynchronous active-low reset
//     bus   : fetch_stage_if.slave (control in, BRAM bus, F/D outputs)
//   The interface instance must use the same ADDR_W as this module.
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          ADDR_W   = 14,
  parameter logic [31:0] NOP_INST = 32'h0000_0001
) (
  input  logic         clk,
  input  logic         rstn,
  fetch_stage_if.slave bus
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic        r_valid;
  logic [31:0] r_fetch_count;

  logic [31:0] w_next_pc;
  logic        w_valid_nxt;
  logic        w_f_valid;
  logic [31:0] w_redirect_tgt;
  logic        w_unused_bits;

  assign w_redirect_tgt = {bus.redirect_pc[31:2], 2'b00};

  // PC bits outside the BRAM word address simply alias; they are not needed.
  assign w_unused_bits = ^{bus.redirect_pc[1:0], w_next_pc[1:0],
                           w_next_pc[31:ADDR_W+2]};

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: BOOT lasts one cycle, HALT is absorbing until reset
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT:  w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = bus.halt ? S_HALT : S_RUN;
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_BOOT;
    endcase
  end

  // Output / datapath-control logic
  always_comb begin
    w_next_pc   = r_pc;
    w_valid_nxt = 1'b0;
    w_f_valid   = 1'b0;
    case (r_state)
      S_BOOT: begin
        // Re-issue the read of the reset PC so its data lands next cycle.
        w_next_pc   = r_pc;
        w_valid_nxt = 1'b1;
      end
      S_RUN: begin
        // A redirect in this cycle means the instruction on f_inst is
        // wrong-path, so it is flushed right here rather than one stage later.
        w_f_valid   = r_valid & ~bus.redirect;
        w_valid_nxt = ~bus.halt;
        if (bus.halt) begin
          w_next_pc = r_pc;
        end else if (bus.redirect) begin
          w_next_pc = w_redirect_tgt;
        end else if (bus.stall) begin
          // Re-reading pc_q keeps f_pc/f_inst stable for any stall length.
          w_next_pc = r_pc;
        end else begin
          w_next_pc = r_pc + 32'd4;
        end
      end
      S_HALT: begin
        w_next_pc = r_pc;
      end
      default: begin
        w_next_pc = r_pc;
      end
    endcase
  end

  // PC / valid / counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc          <= PC_RESET;
      r_valid       <= 1'b0;
      r_fetch_count <= 32'd0;
    end else begin
      r_pc    <= w_next_pc;
      r_valid <= w_valid_nxt;
      if (w_f_valid && !bus.stall) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
    end
  end

  // BRAM address is combinational from next_pc so imem_rdata always matches pc_q.
  assign bus.imem_addr   = w_next_pc[ADDR_W+1:2];
  assign bus.f_pc        = r_pc;
  assign bus.f_valid     = w_f_valid;
  assign bus.f_inst      = w_f_valid ? bus.imem_rdata : NOP_INST;
  assign bus.fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  localparam int          ADDR_W   = 14;
  localparam logic [31:0] PC_RESET = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0001;

  logic clk;
  logic rstn;

  fetch_stage_if #(.ADDR_W(ADDR_W)) bus ();

  fetch_stage #(
    .PC_RESET(PC_RESET),
    .ADDR_W  (ADDR_W),
    .NOP_INST(NOP_INST)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction BRAM, static contents after initialisation.
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr];

  typedef struct {
    logic [31:0]       pc;
    logic [31:0]       inst;
    logic [31:0]       count;
    logic              valid;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: architectural view of the fetch unit.
  logic [31:0] m_pc;
  bit          m_boot;
  bit          m_halted;
  logic [31:0] m_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_next_pc();
    if (m_boot || m_halted)  return m_pc;
    if (bus.halt)            return m_pc;
    if (bus.redirect)        return bus.redirect_pc & 32'hFFFF_FFFC;
    if (bus.stall)           return m_pc;
    return m_pc + 32'd4;
  endfunction

  function automatic bit model_valid();
    return !m_boot && !m_halted && !bus.redirect;
  endfunction

  task automatic push_expect();
    exp_t              e;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       np;
    e.valid = model_valid();
    idx     = m_pc[ADDR_W+1:2];
    e.inst  = e.valid ? mem[idx] : NOP_INST;
    e.pc    = m_pc;
    e.count = m_count;
    np      = model_next_pc();
    e.addr  = np[ADDR_W+1:2];
    q.push_back(e);
  endtask

  // Advance the model across one rising edge using the inputs still applied.
  task automatic model_edge();
    logic [31:0] np;
    np = model_next_pc();
    if (model_valid() && !bus.stall) m_count = m_count + 32'd1;
    m_pc = np;
    if (m_boot)                       m_boot = 1'b0;
    else if (!m_halted && bus.halt)   m_halted = 1'b1;
  endtask

  task automatic model_reset();
    m_pc     = PC_RESET;
    m_boot   = 1'b1;
    m_halted = 1'b0;
    m_count  = 32'd0;
  endtask

  task automatic cyc(input bit st, input bit rd, input logic [31:0] rpc, input bit h);
    @(posedge clk);
    #1;
    model_edge();
    bus.stall       = st;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.halt        = h;
    push_expect();
  endtask

  task automatic check_reset_values(input string tag);
    logic [ADDR_W-1:0] ra;
    ra = PC_RESET[ADDR_W+1:2];
    chk({tag, "_f_valid"}, {31'd0, bus.f_valid}, 32'd0);
    chk({tag, "_f_inst"},  bus.f_inst, NOP_INST);
    chk({tag, "_f_pc"},    bus.f_pc, PC_RESET);
    chk({tag, "_count"},   bus.fetch_count, 32'd0);
    chk({tag, "_addr"},    32'(bus.imem_addr), 32'(ra));
  endtask

  // Release reset away from the clock edge and queue the boot-cycle view.
  task automatic release_reset();
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'd0; bus.halt = 1'b0;
    @(posedge clk);
    #2;
    rstn = 1'b1;
    model_reset();
    push_expect();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must react without an edge.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check_reset_values("async_rst");
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.halt = 1'b0;
    @(posedge clk);
    #1;
    check_reset_values("rst_hold");
    release_reset();
  endtask

  // Monitor: compare every presented cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("f_valid",     {31'd0, bus.f_valid}, {31'd0, e.valid});
        chk("f_pc",        bus.f_pc, e.pc);
        chk("f_inst",      bus.f_inst, e.inst);
        chk("fetch_count", bus.fetch_count, e.count);
        chk("imem_addr",   32'(bus.imem_addr), 32'(e.addr));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d vectors expected completion", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rpc;
    bit          st, rd, h;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = $urandom;
    mem[0] = 32'hAAAA_0000;
    mem[1] = 32'hAAAA_0001;
    rstn = 1'b0;
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'd0; bus.halt = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("por");
    release_reset();

    // Boot, then advance to PC 0x8 and stall three cycles there.
    cyc(0, 0, 0, 0);                 // f_pc 0
    cyc(0, 0, 0, 0);                 // f_pc 4
    cyc(1, 0, 0, 0);                 // f_pc 8, stalled
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);                 // still 8, released
    cyc(0, 0, 0, 0);                 // 0xC
    cyc(0, 1, 32'h0000_0103, 0);     // f_pc 0x10, redirect -> 0x100
    cyc(0, 0, 0, 0);                 // 0x100
    cyc(1, 1, 32'h0000_0200, 0);     // redirect wins over stall
    cyc(0, 0, 0, 0);                 // 0x200
    cyc(0, 1, 32'h0000_0020, 0);
    cyc(0, 0, 0, 1);                 // halt at 0x20
    for (int i = 0; i < 12; i++)
      cyc(i[0], i[1], 32'h0000_0400 + 32'(i) * 4, i[2]);

    // Wrap-around through the top of the address space.
    async_reset();
    cyc(0, 0, 0, 0);
    cyc(0, 1, 32'hFFFF_FFFF, 0);
    cyc(0, 0, 0, 0);                 // f_pc FFFFFFFC, addr 0
    cyc(0, 0, 0, 0);                 // f_pc 0
    cyc(0, 0, 0, 0);

    // Randomized traffic with periodic mid-cycle resets.
    for (int r = 0; r < 4; r++) begin
      async_reset();
      for (int i = 0; i < 300; i++) begin
        st  = ($urandom_range(0, 3) == 0);
        rd  = ($urandom_range(0, 7) == 0);
        h   = ($urandom_range(0, 199) == 0);
        rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : $urandom;
        cyc(st, rd, rpc, h);
      end
    end

    repeat (2) @(posedge clk);
    #6;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
